operand_stage: RTL
==================

Name: operand_stage

Overview:
- Registered, parametrised operand generator for the ID stage of the MIPS pipeline.
- Decodes op/funct into two ALU operands: register, link address, sign/zero/high-extended immediate, or shift amount.
- Resolves register sources through an N-port forwarding network and interlocks on load-use hazards.
- Presents the operands to ID/EX through a valid/ready output register with flush.

Parameters:
- DATA_W, 32, operand and register data width (≥16).
- ADDR_W, 32, instruction address width.
- REG_AW, 5, register-file address width.
- FWD_N, 2, number of forwarding ports; port 0 is the youngest stage and has the highest priority.
- LINK_OFS, 8, byte offset added to addr for JAL/JALR link values.
- CNT_W, 8, width of the saturating stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- flush  in  1  discard the held and the incoming instruction.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  instruction accepted this cycle.
- addr  in  ADDR_W  instruction address.
- op  in  6  opcode.
- funct  in  6  SPECIAL function field.
- shamt  in  5  shift amount.
- imm  in  16  immediate field.
- rs_addr, rt_addr  in  REG_AW  source register indices.
- reg_data_1, reg_data_2  in  DATA_W  register-file read data for rs and rt.
- fwd_valid  in  FWD_N  port carries a register write.
- fwd_pending  in  FWD_N  write data not yet available (load in flight).
- fwd_addr  in  FWD_N*REG_AW  destination indices, packed with port 0 in the LSBs.
- fwd_data  in  FWD_N*DATA_W  write data, packed with port 0 in the LSBs.
- out_valid  out  1  operands valid.
- out_ready  in  1  EX stage accepts.
- operand_1, operand_2  out  DATA_W  registered operands.
- load_use_stall  out  1  interlock active this cycle.
- stall_cycles  out  CNT_W  consecutive interlock cycles, saturating.

Behaviour:
- Reset values: out_valid=0, operand_1=0, operand_2=0, stall_cycles=0, state EMPTY. in_ready and load_use_stall are combinational and read 0 while rst is low.
- Operand 1 select:
  - ADDIU, SLTI, SLTIU, ANDI, ORI, LUI, LB, LBU, LH, LW, SB, SH, SW, and SPECIAL (except below): rs.
  - JAL, and SPECIAL/JALR: addr+LINK_OFS, zero-extended or truncated to DATA_W.
  - SPECIAL with SLL/SRL/SRA: {zeros, shamt}.
  - All other opcodes: 0.
- Operand 2 select:
  - LUI: imm placed in the top 16 bits, zeros below.
  - ADDIU, SLTI, SLTIU, all loads and stores: imm sign-extended to DATA_W.
  - ANDI, ORI: imm zero-extended.
  - SPECIAL: rt.
  - All other opcodes: 0.
- Source resolution:
  - rs is used only when operand 1 selects rs; rt is used only when operand 2 selects rt.
  - For a used source with index ≠ 0, take the lowest-index port with fwd_valid=1 and a matching fwd_addr.
  - If that port has fwd_pending=1, the source is a hazard. Otherwise its fwd_data replaces the register value.
  - With no matching port, the register-file data is used. Index 0 always yields 0 and never matches or forwards.
- Hazards:
  - hazard = in_valid & (rs hazard | rt hazard).
  - load_use_stall = hazard & ~flush.
- Handshake:
  - in_ready = ~hazard & ~flush & (~out_valid | out_ready).
  - accept = in_valid & in_ready; latency is 1 cycle from accept to out_valid.
- State machine (EMPTY / FULL / INTERLOCK):
  - EMPTY: accept → FULL; hazard → INTERLOCK.
  - FULL: accept → FULL, reloading back-to-back; out_ready without accept → EMPTY, or → INTERLOCK if hazard; otherwise hold.
  - INTERLOCK: hazard clears and accept → FULL; hazard clears, no accept, in_valid=0 → EMPTY. While INTERLOCK, if out_valid & out_ready the output is drained (out_valid←0).
  - flush from any state: next state EMPTY, out_valid←0, no accept that cycle. flush has priority over every other event.
- Operand registers update only on accept and hold otherwise, including under flush.
- stall_cycles: +1 per cycle with load_use_stall=1, saturating at all-ones; cleared on any cycle with load_use_stall=0.
- Reset asserted mid-interlock or mid-hold returns immediately to the reset values.

Decomposition:
- Shared package: opcode and funct constants (existing headers), plus the new operand-select enums SEL1_{REG,LINK,SHAMT,ZERO} and SEL2_{REG,SEXT,ZEXT,HI,ZERO} and the state encoding.
- One sub-module, fwd_resolve: a combinational priority match for one source. Inputs: index, register data, forwarding buses. Outputs: value, hazard. Instantiated twice, once for rs and once for rt.

Test Plan:
- ADDIU, imm=0xFFF0, rs=3 with reg_data_1=0x10, no forwarding → 1 cycle later operand_1=0x00000010, operand_2=0xFFFFFFF0, out_valid=1.
- JAL at addr=0x00400010 → operand_1=0x00400018, operand_2=0. SPECIAL/SLL with shamt=7, rt=4, reg_data_2=0x5 → operand_1=7, operand_2=5.
- ADDU rs=rt=8; port1 valid to r8 with data 0x22, port0 valid to r8 with data 0x11 → both operands=0x11. Same test with r0 and the ports matching r0 → both operands=0.
- LW result pending on port0 for r9 for 3 cycles, consumer reads r9 → in_ready=0, load_use_stall=1, stall_cycles 1,2,3. Pending drops with fwd_data=0xABCD → accepted, operand_1=0xABCD, stall_cycles=0.
- out_ready held 0 for 2 cycles with in_valid=1 → operands stable, in_ready=0. out_ready=1 → back-to-back accept, out_valid stays 1.
- flush during INTERLOCK and during FULL → next cycle out_valid=0, state EMPTY. rst pulsed low mid-stall → outputs at their reset values asynchronously.

Source files
------------

// File: rtl/operand_stage_pkg.sv
// Shared opcode, funct, operand-select and state definitions
// for the ID-stage operand generator.
package operand_stage_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0a;
    localparam logic [5:0] OP_SLTIU   = 6'h0b;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SLT  = 6'h2a;

    typedef enum logic [1:0] {
        SEL1_REG,
        SEL1_LINK,
        SEL1_SHAMT,
        SEL1_ZERO
    } sel1_t;

    typedef enum logic [2:0] {
        SEL2_REG,
        SEL2_SEXT,
        SEL2_ZEXT,
        SEL2_HI,
        SEL2_ZERO
    } sel2_t;

    localparam logic [1:0] S_EMPTY     = 2'd0;
    localparam logic [1:0] S_FULL      = 2'd1;
    localparam logic [1:0] S_INTERLOCK = 2'd2;

endpackage

// File: rtl/operand_stage_fwd_resolve.sv
// Priority forwarding match for one register source.
// Port 0 is the youngest writer and wins over higher ports.
module fwd_resolve
    import operand_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int FWD_N  = 2
) (
    input  logic [REG_AW-1:0]       idx,
    input  logic [DATA_W-1:0]       reg_data,
    input  logic [FWD_N-1:0]        fwd_valid,
    input  logic [FWD_N-1:0]        fwd_pending,
    input  logic [FWD_N*REG_AW-1:0] fwd_addr,
    input  logic [FWD_N*DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0]       value,
    output logic                    hazard
);

    // Scan from the oldest port down so the youngest match is last to write
    always_comb begin
        value  = reg_data;
        hazard = 1'b0;
        for (int i = FWD_N - 1; i >= 0; i--) begin
            if (fwd_valid[i] &&
                fwd_addr[i*REG_AW +: REG_AW] == idx) begin
                value  = fwd_data[i*DATA_W +: DATA_W];
                hazard = fwd_pending[i];
            end
        end
        if (idx == '0) begin
            value  = '0;
            hazard = 1'b0;
        end
    end

endmodule

// File: rtl/operand_stage.sv
// ID-stage operand generator: decode, forwarding, load-use
// interlock and a valid/ready output register towards EX.
module operand_stage
    import operand_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int REG_AW   = 5,
    parameter int FWD_N    = 2,
    parameter int LINK_OFS = 8,
    parameter int CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [5:0]              op,
    input  logic [5:0]              funct,
    input  logic [4:0]              shamt,
    input  logic [15:0]             imm,
    input  logic [REG_AW-1:0]       rs_addr,
    input  logic [REG_AW-1:0]       rt_addr,
    input  logic [DATA_W-1:0]       reg_data_1,
    input  logic [DATA_W-1:0]       reg_data_2,
    input  logic [FWD_N-1:0]        fwd_valid,
    input  logic [FWD_N-1:0]        fwd_pending,
    input  logic [FWD_N*REG_AW-1:0] fwd_addr,
    input  logic [FWD_N*DATA_W-1:0] fwd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       operand_1,
    output logic [DATA_W-1:0]       operand_2,
    output logic                    load_use_stall,
    output logic [CNT_W-1:0]        stall_cycles
);

    sel1_t             sel1;
    sel2_t             sel2;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              rs_hz;
    logic              rt_hz;
    logic [ADDR_W-1:0] link_a;
    logic [DATA_W-1:0] op1_d;
    logic [DATA_W-1:0] op2_d;
    logic              hazard;
    logic              accept;
    logic [1:0]        state_q;
    logic [1:0]        state_d;

    fwd_resolve #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .FWD_N  (FWD_N)
    ) u_rs (
        .idx         (rs_addr),
        .reg_data    (reg_data_1),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .value       (rs_val),
        .hazard      (rs_hz)
    );

    fwd_resolve #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .FWD_N  (FWD_N)
    ) u_rt (
        .idx         (rt_addr),
        .reg_data    (reg_data_2),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .value       (rt_val),
        .hazard      (rt_hz)
    );

    // Map opcode/funct to operand sources
    always_comb begin
        sel1 = SEL1_ZERO;
        sel2 = SEL2_ZERO;
        unique case (op)
            OP_SPECIAL: begin
                sel2 = SEL2_REG;
                unique case (funct)
                    FN_SLL, FN_SRL, FN_SRA: sel1 = SEL1_SHAMT;
                    FN_JALR:                sel1 = SEL1_LINK;
                    default:                sel1 = SEL1_REG;
                endcase
            end
            OP_JAL: sel1 = SEL1_LINK;
            OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_LB, OP_LBU, OP_LH, OP_LW,
            OP_SB, OP_SH, OP_SW: begin
                sel1 = SEL1_REG;
                sel2 = SEL2_SEXT;
            end
            OP_ANDI, OP_ORI: begin
                sel1 = SEL1_REG;
                sel2 = SEL2_ZEXT;
            end
            OP_LUI: begin
                sel1 = SEL1_REG;
                sel2 = SEL2_HI;
            end
            default: ;
        endcase
    end

    assign link_a = addr + ADDR_W'(LINK_OFS);

    // Build the next operand values from the selects
    always_comb begin
        unique case (sel1)
            SEL1_REG:   op1_d = rs_val;
            SEL1_LINK:  op1_d = DATA_W'(link_a);
            SEL1_SHAMT: op1_d = DATA_W'(shamt);
            default:    op1_d = '0;
        endcase
        unique case (sel2)
            SEL2_REG:  op2_d = rt_val;
            SEL2_SEXT: op2_d = DATA_W'($signed(imm));
            SEL2_ZEXT: op2_d = DATA_W'(imm);
            SEL2_HI:   op2_d = DATA_W'(imm) << (DATA_W - 16);
            default:   op2_d = '0;
        endcase
    end

    assign hazard = in_valid &
                    (((sel1 == SEL1_REG) & rs_hz) |
                     ((sel2 == SEL2_REG) & rt_hz));

    assign in_ready = rst & ~hazard & ~flush &
                      (~out_valid | out_ready);
    assign load_use_stall = rst & hazard & ~flush;
    assign accept = in_valid & in_ready;

    // Next-state selection; flush overrides everything
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (accept)      state_d = S_FULL;
                    else if (hazard) state_d = S_INTERLOCK;
                end
                S_FULL: begin
                    if (accept)         state_d = S_FULL;
                    else if (out_ready) state_d = hazard ? S_INTERLOCK
                                                         : S_EMPTY;
                end
                S_INTERLOCK: begin
                    if (accept)         state_d = S_FULL;
                    else if (!hazard && !in_valid)
                                        state_d = S_EMPTY;
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // State, output register and operand capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_EMPTY;
            out_valid <= 1'b0;
            operand_1 <= '0;
            operand_2 <= '0;
        end else begin
            state_q <= state_d;
            if (flush)          out_valid <= 1'b0;
            else if (accept)    out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;
            if (accept) begin
                operand_1 <= op1_d;
                operand_2 <= op2_d;
            end
        end
    end

    // Saturating count of consecutive interlock cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (!load_use_stall) begin
            stall_cycles <= '0;
        end else if (!(&stall_cycles)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
